// File: rtl/pos_read_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pos_read_scheduler_pkg
// Description : Shared types and constants for the position-cache read
//               scheduler: FSM state and phase encodings, default sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package pos_read_scheduler_pkg;

    localparam int DEF_NUM_NEIGHBOR_CELLS = 13;
    localparam int DEF_PARTICLE_ID_WIDTH  = 7;
    localparam int DEF_RD_LATENCY         = 1;

    // Home cell plus its half-shell neighbours.
    localparam int NUM_CELLS = DEF_NUM_NEIGHBOR_CELLS + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Phase A serves filter types 22/31/03, phase B the other set.
    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_e;

endpackage
`default_nettype wire

// File: rtl/aligned_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : aligned_delay_line
// Description : Fixed-depth register line that delays a bundle so it lines
//               up with position-cache read data.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               din [WIDTH]   - bundle entering the line
//               dout[WIDTH]   - bundle DEPTH cycles later
// Revision    : 1.0 - initial release
// ============================================================================
module aligned_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RESET_VAL;
        end else begin
            r_pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign dout = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pos_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pos_read_scheduler
// Description : Sweeps a reference particle over the home cell and a common
//               neighbour index over all caches (two phases per index),
//               producing read addresses plus latency-aligned masks.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start             - begin a home cell (accepted when idle)
//               particle_count    - per-cell counts, home cell in LSB slice
//               back_pressure     - filters full, hold issue
//               ref_rd_addr       - home-cache reference address
//               nb_rd_addr        - neighbour address to all caches
//               rd_en, busy       - issue enable, scheduler active
//               phase, pause_reading, broadcast_done, ref_not_read_yet,
//               ref_valid, done   - aligned with cache read data
// Revision    : 1.0 - initial release
// ============================================================================
module pos_read_scheduler
    import pos_read_scheduler_pkg::*;
#(
    parameter int NUM_NEIGHBOR_CELLS = DEF_NUM_NEIGHBOR_CELLS,
    parameter int PARTICLE_ID_WIDTH  = DEF_PARTICLE_ID_WIDTH,
    parameter int RD_LATENCY         = DEF_RD_LATENCY
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start,
    input  logic [(NUM_NEIGHBOR_CELLS+1)*PARTICLE_ID_WIDTH-1:0] particle_count,
    input  logic                                                back_pressure,
    output logic [PARTICLE_ID_WIDTH-1:0]                        ref_rd_addr,
    output logic [PARTICLE_ID_WIDTH-1:0]                        nb_rd_addr,
    output logic                                                rd_en,
    output logic                                                busy,
    output logic                                                phase,
    output logic                                                pause_reading,
    output logic [NUM_NEIGHBOR_CELLS:0]                         broadcast_done,
    output logic                                                ref_not_read_yet,
    output logic                                                ref_valid,
    output logic                                                done
);

    localparam int C_NC = NUM_NEIGHBOR_CELLS + 1;
    localparam int C_W  = PARTICLE_ID_WIDTH;
    localparam int C_AW = C_NC + 5;
    localparam logic [C_W:0]    C_ONE      = {{C_W{1'b0}}, 1'b1};
    // Idle bundle: every cell reported exhausted, nothing valid.
    localparam logic [C_AW-1:0] C_AL_RESET = {2'b00, {C_NC{1'b1}}, 3'b000};

    state_e           r_state, w_state_nx;
    phase_e           r_ph, w_ph_nx;
    logic [C_W-1:0]   r_ref, w_ref_nx;
    logic [C_W-1:0]   r_nb, w_nb_nx;
    logic [C_W-1:0]   r_max, w_max;
    logic [C_W-1:0]   r_count [C_NC];
    logic [C_W:0]     w_nb_inc, w_ref_inc;
    logic [C_NC-1:0]  w_bd;
    logic             w_nry, w_rv, w_dn;
    logic [C_AW-1:0]  w_al_in, w_al_out;

    // One extra bit so the last index of a full 2^W-1 cell does not wrap.
    assign w_nb_inc  = {1'b0, r_nb} + C_ONE;
    assign w_ref_inc = {1'b0, r_ref} + C_ONE;

    always_comb begin
        w_max = r_count[0];
        for (int k = 1; k < C_NC; k++) begin
            if (r_count[k] > w_max) w_max = r_count[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ph    <= PH_A;
            r_ref   <= '0;
            r_nb    <= '0;
            r_max   <= '0;
            for (int k = 0; k < C_NC; k++) r_count[k] <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ph    <= w_ph_nx;
            r_ref   <= w_ref_nx;
            r_nb    <= w_nb_nx;
            if (r_state == ST_IDLE && start) begin
                for (int k = 0; k < C_NC; k++)
                    r_count[k] <= particle_count[k*C_W +: C_W];
            end
            if (r_state == ST_LOAD) r_max <= w_max;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ph_nx    = r_ph;
        w_ref_nx   = r_ref;
        w_nb_nx    = r_nb;
        case (r_state)
            ST_IDLE: if (start) w_state_nx = ST_LOAD;
            ST_LOAD: begin
                w_ref_nx   = '0;
                w_nb_nx    = '0;
                w_ph_nx    = PH_A;
                w_state_nx = (r_count[0] == '0) ? ST_FIN : ST_RUN;
            end
            ST_RUN: begin
                // Under back pressure everything holds; the repeated read is harmless.
                if (!back_pressure) begin
                    if (r_ph == PH_A) begin
                        w_ph_nx = PH_B;
                    end else if (w_nb_inc < {1'b0, r_max}) begin
                        w_nb_nx = w_nb_inc[C_W-1:0];
                        w_ph_nx = PH_A;
                    end else begin
                        w_nb_nx  = '0;
                        w_ph_nx  = PH_A;
                        w_ref_nx = w_ref_inc[C_W-1:0];
                        if (w_ref_inc == {1'b0, r_count[0]}) w_state_nx = ST_FIN;
                    end
                end
            end
            ST_FIN:  w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rv  = (r_state == ST_RUN);
        w_dn  = (r_state == ST_FIN);
        // Home-cell pairs with nb > ref are produced when the roles swap.
        w_nry = w_rv && (r_nb <= r_ref);
        w_bd  = '1;
        if (w_rv) begin
            for (int k = 0; k < C_NC; k++) w_bd[k] = (r_nb >= r_count[k]);
        end
    end

    assign w_al_in = {r_ph, back_pressure, w_bd, w_nry, w_rv, w_dn};

    aligned_delay_line #(
        .WIDTH     (C_AW),
        .DEPTH     (RD_LATENCY),
        .RESET_VAL (C_AL_RESET)
    ) u_align (
        .clk  (clk),
        .rst  (rst),
        .din  (w_al_in),
        .dout (w_al_out)
    );

    assign {phase, pause_reading, broadcast_done,
            ref_not_read_yet, ref_valid, done} = w_al_out;

    assign ref_rd_addr = r_ref;
    assign nb_rd_addr  = r_nb;
    assign rd_en       = (r_state == ST_RUN);
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/pos_read_scheduler.md
# pos_read_scheduler

Sequences position-cache reads for one home cell and its 13 half-shell neighbour cells, feeding the position data distributor. For each reference particle in the home cell, it sweeps a neighbour-particle index across all 14 caches in two phases (7 filter lanes each). It generates the per-cell broadcast-done, reference-valid and self-pair masks, delayed to line up with cache read data. It also stalls cleanly under filter back pressure.

## Interface
- NUM_NEIGHBOR_CELLS, 13, neighbour cells per home cell; NUM_NEIGHBOR_CELLS+1 caches in total.
- PARTICLE_ID_WIDTH, 7, particle address width; per-cell count range 0..2^W-1.
- RD_LATENCY, 1, position-cache read latency in cycles; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse to begin a home cell; ignored unless idle
- particle_count  in  (NUM_NEIGHBOR_CELLS+1)*PARTICLE_ID_WIDTH  per-cell counts; LSB slice is the home cell, order matches cache order; sampled on accepted start
- back_pressure  in  1  filters cannot accept; hold issue
- ref_rd_addr  out  PARTICLE_ID_WIDTH  home-cache address of the reference particle
- nb_rd_addr  out  PARTICLE_ID_WIDTH  common neighbour address to all caches
- rd_en  out  1  cache read enable (issue side)
- busy  out  1  state ≠ IDLE
- phase  out  1  aligned phase to distributor
- pause_reading  out  1  aligned back_pressure
- broadcast_done  out  NUM_NEIGHBOR_CELLS+1  aligned; bit k = cell k exhausted
- ref_not_read_yet  out  1  aligned; home-cell pair is not j>i
- ref_valid  out  1  aligned
- done  out  1  aligned one-cycle pulse after the last aligned data

## Operation
- FSM states:
  - IDLE: on start, latch counts into count_reg, go to LOAD.
  - LOAD: one cycle. Register max_count = max over the 14 count_reg values. If count_reg[home] == 0, go to FIN; else ref=0, nb=0, ph=0, go to RUN.
  - RUN: issues one read per cycle, described below.
  - FIN: one cycle, then IDLE.
- RUN with back_pressure=1: addresses, ph and counters hold; rd_en stays 1 (the re-read is harmless).
- RUN with back_pressure=0:
  - ph=0 → ph=1.
  - ph=1 and nb+1 < max_count → nb+1, ph=0.
  - ph=1 and nb+1 == max_count → nb=0, ph=0, ref+1.
  - After that, if ref+1 == count_reg[home] → FIN.
- Issue-side masks:
  - bd[k] = (nb ≥ count_reg[k]).
  - nry = (nb ≤ ref).
  - rv = (state == RUN).
  - dn = (state == FIN).
  - Outside RUN: bd = all ones, rv = 0, nry = 0.
- Alignment: {ph, back_pressure, bd, nry, rv, dn} pass through an RD_LATENCY-deep register line and drive phase, pause_reading, broadcast_done, ref_not_read_yet, ref_valid and done.
- ref_rd_addr = ref, nb_rd_addr = nb, rd_en = (state == RUN); all undelayed.
- Arithmetic: nb+1 and ref+1 are computed at PARTICLE_ID_WIDTH+1 bits, so no wrap occurs at count 2^W-1.
- Filter almost-full thresholds must leave ≥ RD_LATENCY entries of slack, because reads in flight are not cancelled.

## Timing
- Reset: state=IDLE, counters=0, count_reg=0, max_count=0. Outputs reset to:
  - ref_rd_addr=0, nb_rd_addr=0, rd_en=0, busy=0
  - phase=0, pause_reading=0, broadcast_done=all ones
  - ref_not_read_yet=0, ref_valid=0, done=0
- Reset mid-RUN aborts the cell; no done is emitted.
- start accepted at edge e0 → LOAD after e0 → RUN after e1. The first rd_en cycle follows e1.
- Unstalled, the cell takes count_reg[home] × 2 × max_count RUN cycles.
- done appears RD_LATENCY cycles after the single FIN cycle.
- start during busy is ignored. start in the same cycle as rst is ignored.
- back_pressure outside RUN has no effect.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE, LOAD, RUN, FIN)
  - phase encoding (0 = types 22/31/03 set A, 1 = set B)
  - NUM_CELLS = NUM_NEIGHBOR_CELLS+1
- One sub-module, aligned_delay_line: parameterised width and depth, reset value is a parameter, used for the aligned bundle.

## Test plan
- Home count 3, all other counts 3, no stall → 18 RUN cycles. Then:
  - ref_not_read_yet pattern for ref=1: nb=0,1 high; nb=2 low.
  - done exactly once, 1+RD_LATENCY cycles after the last rd_en.
- Counts home=2, cell 5=4, others=1 → max_count=4. Then:
  - broadcast_done[5]=0 for nb 0..3.
  - bits 0..4 and 6..13 high for nb ≥ 2 (home) or ≥ 1 (others).
- Home count 0 → no rd_en, done pulse RD_LATENCY cycles after FIN, busy high for exactly 2 cycles.
- back_pressure held 3 cycles at ref=0, nb=1, ph=1 → addresses frozen; pause_reading high 3 cycles, shifted by RD_LATENCY; total cycles +3.
- All counts 127 (W=7) → nb reaches 126 and wraps to 0 correctly; 127×254 RUN cycles.
- rst asserted mid-RUN, then start → clean restart from ref=0, nb=0, ph=0; no stale done.
